axi_resp_id_tracker: RTL
========================

// Module: axi_resp_id_tracker
// PURPOSE
//  Per-direction outstanding-transaction table feeding the slave router's response demux select.
//  Records which master port issued each AXI ID on address accept.
//  Returns that port one-hot when the response with the same ID returns.
//  Retires the entry on B handshake or on the R handshake carrying RLAST.
//  Two instances per router: one write (AW/B), one read (AR/R).
// PARAMETERS
//  AXI_ID_WIDTH     1   ID width; table has 2**AXI_ID_WIDTH entries
//  AXI_MASTER_PORT  2   number of upstream master ports (one-hot width)
//  MAX_OUTSTANDING  8   max in-flight transactions per ID; CNT_W = clog2(MAX_OUTSTANDING+1) (localparam)
// PORTS
//  ACLK           in   1                clock
//  ARESETN        in   1                reset, asynchronous, active-low
//  alloc_vld_i    in   1                address handshake pending (AW/ARVALID of granted port)
//  alloc_id_i     in   AXI_ID_WIDTH     ID of that address beat
//  alloc_port_i   in   AXI_MASTER_PORT  one-hot granted master port
//  alloc_rdy_o    out  1                table can accept; router ANDs into M_AXI_AW/ARVALID
//  release_vld_i  in   1                B handshake, or R handshake with RLAST
//  release_id_i   in   AXI_ID_WIDTH     BID / RID of the released response
//  lookup_id_i    in   AXI_ID_WIDTH     response ID at router FIFO head (mst_*_resp_decode_id_o)
//  lookup_trgt_o  out  AXI_MASTER_PORT  one-hot owner (mst_*_resp_decode_trgt_i); 0 if no entry
//  lookup_hit_o   out  1                entry for lookup_id_i has count != 0
//  busy_o         out  1                any entry count != 0
//  err_release_o  out  1                one-cycle pulse: release of ID with count 0
// BEHAVIOUR
//  State per ID: owner[AXI_MASTER_PORT] and cnt[CNT_W]. Reset: all owner=0, cnt=0.
//  Outputs out of reset: lookup_trgt_o=0, lookup_hit_o=0, busy_o=0, err_release_o=0.
//  alloc_rdy_o is combinational from table state, alloc_id_i and alloc_port_i, never from alloc_vld_i.
//  alloc_rdy_o=1 iff alloc_port_i is one-hot AND one of:
//   - cnt[id]==0
//   - owner[id]==alloc_port_i AND cnt[id]<MAX_OUTSTANDING
//  Different owner with cnt!=0 -> rdy=0 (stall: same ID from two ports cannot be demuxed).
//  Accept = alloc_vld_i & alloc_rdy_o; at most one per cycle. Table updates at the next ACLK edge:
//   - cnt+1
//   - owner<=alloc_port_i
//  Release with cnt[id]!=0: cnt-1 next edge; cnt reaching 0 clears owner to 0.
//  Release with cnt[id]==0: no state change; err_release_o=1 next cycle (registered pulse).
//  Alloc and release, same ID, same cycle: cnt unchanged, owner kept.
//   - Alloc rdy is evaluated on pre-update state, so a release never unblocks an alloc in the same cycle.
//  Alloc and release, different IDs, same cycle: both applied independently.
//  Lookup is combinational on current (pre-update) state.
//   - A beat released this cycle still routes to its owner; zero added latency.
//  cnt never wraps: saturation is prevented by alloc_rdy_o; no underflow (error path above).
//  busy_o = OR of (cnt!=0), combinational from registers.
//  Reset mid-operation: all entries cleared asynchronously.
//   - Router FIFOs reset on the same ARESETN, so no stale responses remain.
// STRUCTURE
//  Shared include axi_crossbar_defs.vh holds:
//   - clog2 function
//   - onehot check function
//   - BRESP/RRESP encodings
//  Sub-module axi_id_entry: one per ID (generate loop), holds owner+cnt.
//   - Inputs: inc, dec, port.
//   - Outputs: owner, cnt_nz, full.
//  Top level: ID decode of alloc/release/lookup, rdy logic, busy OR-reduce, error pulse register.
// TESTING
//  Reset, then lookup_id=0 -> trgt=0, hit=0, busy=0, alloc_rdy=1 for port 2'b01.
//  Alloc ID0 port 01; next cycle lookup ID0 -> trgt=01, hit=1.
//   - Alloc ID0 port 10 -> rdy=0 until release ID0, then rdy=1 one cycle after release.
//  8 allocs ID1 port 10 (MAX=8) -> 9th sees rdy=0; one release -> rdy=1; 8 releases -> cnt=0, owner=0, busy=0.
//  ID1 at cnt=3: simultaneous alloc+release ID1 -> cnt stays 3.
//   - Lookup during release cycle returns 10.
//  Release ID0 with cnt=0 -> err_release_o=1 exactly one cycle, state unchanged.
//  Alloc port 2'b11 or 2'b00 -> rdy=0.
//  Drop ARESETN with 4 entries live -> all outputs 0 immediately; busy=0.

Source files
------------

// File: rtl/axi_resp_id_tracker_pkg.sv
// Shared crossbar definitions for the response ID tracker: response encodings and
// elaboration/decode helpers.
package axi_resp_id_tracker_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Callers zero-extend narrower port vectors to 32 bits.
    function automatic logic is_onehot(input logic [31:0] vec);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(vec[i]);
        return (n == 1);
    endfunction

endpackage

// File: rtl/axi_resp_id_tracker_entry.sv
// One outstanding-transaction slot: owning master port plus in-flight count for a single AXI ID.
module axi_resp_id_tracker_entry #(
    parameter int AXI_MASTER_PORT = 2,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       inc,
    input  logic                       dec,
    input  logic [AXI_MASTER_PORT-1:0] port,
    output logic [AXI_MASTER_PORT-1:0] owner,
    output logic                       cnt_nz,
    output logic                       full
);

    logic [CNT_W-1:0] cnt;

    // dec is only ever raised while cnt != 0, so underflow cannot occur here.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt   <= '0;
            owner <= '0;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    cnt   <= cnt + CNT_W'(1);
                    owner <= port;
                end
                2'b01: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) owner <= '0;
                end
                default: ;
            endcase
        end
    end

    assign cnt_nz = (cnt != '0);
    assign full   = (cnt == CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/axi_resp_id_tracker.sv
// Outstanding-transaction table per direction: remembers which master port issued each ID
// and returns it one-hot for the response demux.
module axi_resp_id_tracker
    import axi_resp_id_tracker_pkg::*;
#(
    parameter int AXI_ID_WIDTH    = 1,
    parameter int AXI_MASTER_PORT = 2,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       alloc_vld_i,
    input  logic [AXI_ID_WIDTH-1:0]    alloc_id_i,
    input  logic [AXI_MASTER_PORT-1:0] alloc_port_i,
    output logic                       alloc_rdy_o,
    input  logic                       release_vld_i,
    input  logic [AXI_ID_WIDTH-1:0]    release_id_i,
    input  logic [AXI_ID_WIDTH-1:0]    lookup_id_i,
    output logic [AXI_MASTER_PORT-1:0] lookup_trgt_o,
    output logic                       lookup_hit_o,
    output logic                       busy_o,
    output logic                       err_release_o
);

    localparam int N_ID  = 2 ** AXI_ID_WIDTH;
    localparam int CNT_W = clog2(MAX_OUTSTANDING + 1);

    logic [AXI_MASTER_PORT-1:0] owner [N_ID];
    logic [N_ID-1:0]            cnt_nz;
    logic [N_ID-1:0]            full;
    logic [N_ID-1:0]            inc;
    logic [N_ID-1:0]            dec;
    logic                       err_q;

    for (genvar g = 0; g < N_ID; g++) begin : g_entry
        assign inc[g] = alloc_vld_i & alloc_rdy_o & (alloc_id_i == AXI_ID_WIDTH'(g));
        assign dec[g] = release_vld_i & cnt_nz[g] & (release_id_i == AXI_ID_WIDTH'(g));

        axi_resp_id_tracker_entry #(
            .AXI_MASTER_PORT (AXI_MASTER_PORT),
            .MAX_OUTSTANDING (MAX_OUTSTANDING),
            .CNT_W           (CNT_W)
        ) u_entry (
            .ACLK    (ACLK),
            .ARESETN (ARESETN),
            .inc     (inc[g]),
            .dec     (dec[g]),
            .port    (alloc_port_i),
            .owner   (owner[g]),
            .cnt_nz  (cnt_nz[g]),
            .full    (full[g])
        );
    end

    // A second port may not share a live ID: its responses could not be demuxed.
    assign alloc_rdy_o = is_onehot(32'(alloc_port_i)) &
                         (!cnt_nz[alloc_id_i] |
                          ((owner[alloc_id_i] == alloc_port_i) & !full[alloc_id_i]));

    assign lookup_trgt_o = owner[lookup_id_i];
    assign lookup_hit_o  = cnt_nz[lookup_id_i];
    assign busy_o        = |cnt_nz;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) err_q <= 1'b0;
        else          err_q <= release_vld_i & !cnt_nz[release_id_i];
    end

    assign err_release_o = err_q;

endmodule
